// File: rtl/ti_sbox_seq_if.sv
// Narrow word stream bundle for the TI share sequencer: input words in,
// serialised output shares out, each with a valid/ready handshake.
interface ti_sbox_seq_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/ti_sbox_seq.sv
// Share sequencer for a TI masked S-box core: deserialises shares and fresh
// randomness, fires the core, waits its latency, then serialises the result.
module ti_sbox_seq #(
  parameter int W        = 8,
  parameter int N_SHARES = 3,
  parameter int N_RAND   = 2,
  parameter int CORE_LAT = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  ti_sbox_seq_if.slave                           bus,
  input  logic                                   recombine,
  output logic [N_SHARES*W-1:0]                  core_shares,
  output logic [((N_RAND > 0) ? N_RAND : 1)*W-1:0] core_rand,
  output logic                                   core_start,
  input  logic [N_SHARES*W-1:0]                  core_out_shares,
  output logic                                   busy
);

  localparam int NW  = N_SHARES + N_RAND;
  localparam int WCW = (NW > 1) ? $clog2(NW) : 1;
  localparam int LW  = (CORE_LAT > 0) ? $clog2(CORE_LAT + 1) : 1;
  localparam int OCW = (N_SHARES > 1) ? $clog2(N_SHARES) : 1;
  localparam int RW  = ((N_RAND > 0) ? N_RAND : 1) * W;

  typedef enum logic [1:0] {S_LOAD, S_WAIT, S_UNLOAD} state_e;

  state_e                state_q, state_d;
  logic [WCW-1:0]        wcnt_q, wcnt_d;
  logic [LW-1:0]         lat_q, lat_d;
  logic [OCW-1:0]        ocnt_q, ocnt_d;
  logic [N_SHARES*W-1:0] shares_q, shares_d;
  logic [RW-1:0]         rand_q, rand_d;
  logic [N_SHARES*W-1:0] obuf_q, obuf_d;
  logic                  rec_q, rec_d;

  logic in_acc, out_acc, last_word, lat_done, out_is_last;
  logic [W-1:0] share_sel;

  function automatic logic [W-1:0] xor_shares(input logic [N_SHARES*W-1:0] v);
    logic [W-1:0] acc;
    acc = '0;
    for (int k = 0; k < N_SHARES; k++) acc = acc ^ v[k*W +: W];
    return acc;
  endfunction

  assign in_acc      = (state_q == S_LOAD) && bus.in_valid;
  assign out_acc     = (state_q == S_UNLOAD) && bus.out_ready;
  assign last_word   = (wcnt_q == WCW'(NW - 1));
  assign lat_done    = (lat_q == LW'(CORE_LAT));
  assign out_is_last = rec_q || (ocnt_q == OCW'(N_SHARES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_LOAD;
      wcnt_q   <= '0;
      lat_q    <= '0;
      ocnt_q   <= '0;
      shares_q <= '0;
      rand_q   <= '0;
      obuf_q   <= '0;
      rec_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      lat_q    <= lat_d;
      ocnt_q   <= ocnt_d;
      shares_q <= shares_d;
      rand_q   <= rand_d;
      obuf_q   <= obuf_d;
      rec_q    <= rec_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_LOAD:   if (in_acc && last_word) state_d = S_WAIT;
      S_WAIT:   if (lat_done) state_d = S_UNLOAD;
      S_UNLOAD: if (out_acc && out_is_last) state_d = S_LOAD;
      default:  state_d = S_LOAD;
    endcase
  end

  // Each counter returns to zero when its state is left, so a new packet
  // always starts from slot 0 without any explicit clear step.
  always_comb begin
    wcnt_d   = wcnt_q;
    lat_d    = lat_q;
    ocnt_d   = ocnt_q;
    shares_d = shares_q;
    rand_d   = rand_q;
    obuf_d   = obuf_q;
    rec_d    = rec_q;
    unique case (state_q)
      S_LOAD: begin
        if (in_acc) begin
          for (int k = 0; k < N_SHARES; k++)
            if (wcnt_q == WCW'(k)) shares_d[k*W +: W] = bus.in_data;
          for (int j = 0; j < N_RAND; j++)
            if (wcnt_q == WCW'(N_SHARES + j)) rand_d[j*W +: W] = bus.in_data;
          wcnt_d = last_word ? '0 : wcnt_q + WCW'(1);
        end
      end
      S_WAIT: begin
        if (lat_q == '0) rec_d = recombine;
        if (lat_done) begin
          obuf_d = core_out_shares;
          lat_d  = '0;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      S_UNLOAD: begin
        if (out_acc) ocnt_d = out_is_last ? '0 : ocnt_q + OCW'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    share_sel = '0;
    for (int k = 0; k < N_SHARES; k++)
      if (ocnt_q == OCW'(k)) share_sel = obuf_q[k*W +: W];
  end

  always_comb begin
    bus.in_ready  = (state_q == S_LOAD);
    bus.out_valid = (state_q == S_UNLOAD);
    bus.out_last  = (state_q == S_UNLOAD) && out_is_last;
    bus.out_data  = rec_q ? xor_shares(obuf_q) : share_sel;
    core_start    = (state_q == S_WAIT) && (lat_q == '0);
    busy          = !((state_q == S_LOAD) && (wcnt_q == '0));
  end

  assign core_shares = shares_q;
  assign core_rand   = rand_q;

endmodule

// File: tb/tb_ti_sbox_seq.sv
// Directed bench for ti_sbox_seq with a latency-2 inverting core model and
// a scoreboard of expected output words.
module tb_ti_sbox_seq;
  localparam int W  = 8;
  localparam int NS = 3;
  localparam int NR = 2;
  localparam int CL = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        recombine;
  logic [23:0] core_shares;
  logic [15:0] core_rand;
  logic        core_start;
  logic [23:0] core_out_shares;
  logic        busy;

  always #5 clk = ~clk;

  ti_sbox_seq_if #(.W(W)) bus ();

  ti_sbox_seq #(.W(W), .N_SHARES(NS), .N_RAND(NR), .CORE_LAT(CL)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .recombine       (recombine),
    .core_shares     (core_shares),
    .core_rand       (core_rand),
    .core_start      (core_start),
    .core_out_shares (core_out_shares),
    .busy            (busy)
  );

  // Core model: result valid only in the second cycle after core_start.
  int core_cnt;
  always @(posedge clk) begin
    if (rst)             core_cnt <= 0;
    else if (core_start) core_cnt <= 1;
    else if (core_cnt == 1) core_cnt <= 2;
    else                 core_cnt <= 0;
  end
  assign core_out_shares = (core_cnt == 2) ? ~core_shares : 24'h5A5A5A;

  typedef struct packed {
    logic [7:0] d;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  int   n_err = 0;
  int   n_chk = 0;

  localparam logic [39:0] PKT_A = 40'h5AA5332211;
  localparam logic [39:0] PKT_B = 40'h0000030201;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_in_ready",    32'(bus.in_ready),  32'd1);
    chk("rst_out_valid",   32'(bus.out_valid), 32'd0);
    chk("rst_out_last",    32'(bus.out_last),  32'd0);
    chk("rst_core_start",  32'(core_start),    32'd0);
    chk("rst_busy",        32'(busy),          32'd0);
    chk("rst_out_data",    32'(bus.out_data),  32'd0);
    chk("rst_core_shares", 32'(core_shares),   32'd0);
    chk("rst_core_rand",   32'(core_rand),     32'd0);
  endtask

  // Offer one word from a negedge; returns at the negedge after the accepting edge.
  task automatic put_word(input logic [7:0] d, output int waited);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    waited = 0;
    while (!bus.in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chk("in_accept", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
  endtask

  task automatic drain(input int stall);
    exp_t e;
    int   st = 0;
    int   c  = 0;
    while (exp_q.size() > 0 && c < 200) begin
      if (bus.out_valid) begin
        e = exp_q[0];
        chk("out_data", 32'(bus.out_data), 32'(e.d));
        chk("out_last", 32'(bus.out_last), 32'(e.last));
        if (st < stall) begin
          bus.out_ready = 1'b0;
          chk("in_ready_stall", 32'(bus.in_ready), 32'd0);
          st++;
        end else begin
          bus.out_ready = 1'b1;
          void'(exp_q.pop_front());
          st = 0;
        end
      end else begin
        bus.out_ready = 1'b0;
      end
      @(negedge clk);
      c++;
    end
    bus.out_ready = 1'b0;
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic run_packet(input logic [39:0] pkt, input bit rec, input bit gaps,
                            input int stall, input bit hold, input logic [7:0] hold_word,
                            input bit chk_w0);
    exp_t       e;
    logic [7:0] x;
    int         w;
    x = '0;
    if (rec) begin
      for (int k = 0; k < 3; k++) x = x ^ ~pkt[k*8 +: 8];
      e.d = x; e.last = 1'b1;
      exp_q.push_back(e);
    end else begin
      for (int k = 0; k < 3; k++) begin
        e.d = ~pkt[k*8 +: 8]; e.last = (k == 2);
        exp_q.push_back(e);
      end
    end
    for (int i = 0; i < 5; i++) begin
      put_word(pkt[i*8 +: 8], w);
      if (chk_w0 && i == 0) chk("b2b_first_wait", 32'(w), 32'd0);
      if (gaps && i < 4) begin
        bus.in_valid = 1'b0;
        repeat (2) begin
          chk("busy_gap", 32'(busy), 32'd1);
          @(negedge clk);
        end
      end
    end
    // cycle +1 after the last accept
    bus.in_valid = hold;
    bus.in_data  = hold_word;
    recombine    = rec;
    chk("core_start_p1", 32'(core_start),  32'd1);
    chk("core_shares",   32'(core_shares), 32'(pkt[23:0]));
    chk("core_rand",     32'(core_rand),   32'(pkt[39:24]));
    chk("in_ready_wait", 32'(bus.in_ready), 32'd0);
    chk("busy_wait",     32'(busy),        32'd1);
    @(negedge clk);
    recombine = ~rec;
    chk("core_start_p2", 32'(core_start),    32'd0);
    chk("out_valid_p2",  32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("out_valid_p3",  32'(bus.out_valid), 32'd0);
    chk("core_hold_p3",  32'(core_shares),   32'(pkt[23:0]));
    @(negedge clk);
    chk("out_valid_p4",  32'(bus.out_valid), 32'd1);
    drain(stall);
    recombine = 1'b0;
    chk("post_in_ready",  32'(bus.in_ready),  32'd1);
    chk("post_busy",      32'(busy),          32'd0);
    chk("post_out_valid", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst           = 1'b1;
    recombine     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset_vals();

    // basic packet
    run_packet(PKT_A, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0);

    // output backpressure with in_valid held high
    run_packet(PKT_A, 1'b0, 1'b0, 3, 1'b1, 8'h77, 1'b0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("bp_no_accept", 32'(busy), 32'd0);

    // recombine mode
    run_packet(PKT_A, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0);

    // input gaps
    run_packet(PKT_A, 1'b0, 1'b1, 0, 1'b0, 8'h00, 1'b0);

    // reset after two words
    put_word(8'h11, w);
    put_word(8'h22, w);
    bus.in_valid = 1'b0;
    chk("busy_two_words", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals();
    run_packet(PKT_A, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0);

    // reset during unload of word 1
    for (int i = 0; i < 5; i++) put_word(PKT_A[i*8 +: 8], w);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("ur_valid",  32'(bus.out_valid), 32'd1);
    chk("ur_word0",  32'(bus.out_data),  32'hEE);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("ur_word1",  32'(bus.out_data),  32'hDD);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals();
    run_packet(PKT_A, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0);

    // back-to-back packets A then B
    run_packet(PKT_A, 1'b0, 1'b0, 0, 1'b1, PKT_B[7:0], 1'b0);
    run_packet(PKT_B, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
